// File: rtl/signal_conflict_monitor_if.sv
// Lamp bus between the traffic-light FSM, the conflict monitor and the lamp drivers.
// master = stimulus/FSM side, slave = monitor side.
interface signal_conflict_monitor_if;
  logic [7:0] lights_i;
  logic       clr_i;
  logic [7:0] lights_o;
  logic       fault_o;
  logic [4:0] fault_code_o;

  modport master (output lights_i, clr_i, input lights_o, fault_o, fault_code_o);
  modport slave  (input lights_i, clr_i, output lights_o, fault_o, fault_code_o);
endinterface

// File: rtl/signal_conflict_monitor.sv
// Safety stage between the traffic-light FSM and the lamp drivers: one-cycle pass-through,
// latches a fault and forces a fail-safe pattern on unsafe lamps. Option macro: FAULT_FLASH_EN.
module signal_conflict_monitor #(
  parameter int MIN_YELLOW_CYC = 4,
  parameter int MAX_STUCK_CYC  = 64,
  parameter int FLASH_CYC      = 8
) (
  input logic                      clk,
  input logic                      reset,
  signal_conflict_monitor_if.slave mon
);
  localparam int YW = $clog2(MIN_YELLOW_CYC + 1);
  localparam int SW = $clog2(MAX_STUCK_CYC + 1);
  localparam logic [YW-1:0] YMIN     = YW'(MIN_YELLOW_CYC);
  localparam logic [SW-1:0] SMAX     = SW'(MAX_STUCK_CYC);
  localparam logic [SW-1:0] SLIMIT   = SW'(MAX_STUCK_CYC - 1);
  localparam logic [7:0]    ALL_RED  = 8'h00;
  localparam logic [7:0]    ALL_YEL  = 8'h55;

  typedef enum logic {MONITOR, FAULT} state_e;

  state_e        state_q, state_d;
  logic [7:0]    prev_q;
  logic [7:0]    lights_q, lights_d;
  logic          fault_q, fault_d;
  logic [4:0]    code_q, code_d;
  logic [SW-1:0] stuck_q, stuck_d;
  logic [YW-1:0] ycnt_q [4];
  logic [YW-1:0] ycnt_d [4];
  logic [YW-1:0] ycnt_run [4];

  logic [3:0]    is_green, is_yellow, is_illegal, skip_v, short_v;
  logic          conflict, same, stuck_v, clr_ok;
  logic [SW-1:0] stuck_run;
  logic [4:0]    mask;

  for (genvar gi = 0; gi < 4; gi++) begin : g_app
    logic [1:0] cur, prv;
    assign cur            = mon.lights_i[2*gi +: 2];
    assign prv            = prev_q[2*gi +: 2];
    assign is_green[gi]   = (cur == 2'b10);
    assign is_yellow[gi]  = (cur == 2'b01);
    assign is_illegal[gi] = (cur == 2'b11);
    assign skip_v[gi]     = (prv == 2'b10) && (cur == 2'b00);
    assign short_v[gi]    = (prv == 2'b01) && !is_yellow[gi] && (ycnt_q[gi] < YMIN);
    // Counter value after this cycle: 1 on yellow entry, counting up to the minimum while held.
    assign ycnt_run[gi]   = (is_yellow[gi] && prv != 2'b01) ? YW'(1) :
                            (is_yellow[gi] && ycnt_q[gi] < YMIN) ? ycnt_q[gi] + YW'(1) :
                            ycnt_q[gi];
  end

  assign conflict  = ($countones(is_green) >= 2);
  assign same      = (mon.lights_i == prev_q);
  assign stuck_run = !same ? '0 : (stuck_q == SMAX) ? stuck_q : stuck_q + SW'(1);
  assign stuck_v   = same && (stuck_run >= SLIMIT);
  assign mask      = {stuck_v, |short_v, |skip_v, conflict, |is_illegal};
  assign clr_ok    = mon.clr_i && !(|is_illegal) && !conflict;

`ifdef FAULT_FLASH_EN
  localparam int FW = $clog2(FLASH_CYC + 1);
  localparam logic [FW-1:0] FLAST = FW'(FLASH_CYC - 1);
  logic [FW-1:0] flash_q, flash_d;
`endif

  always_comb begin
    state_d  = state_q;
    lights_d = lights_q;
    fault_d  = fault_q;
    code_d   = code_q;
    stuck_d  = stuck_run;
    for (int i = 0; i < 4; i++) ycnt_d[i] = ycnt_run[i];
`ifdef FAULT_FLASH_EN
    flash_d  = flash_q;
`endif
    case (state_q)
      MONITOR: begin
        if (|mask) begin
          state_d  = FAULT;
          fault_d  = 1'b1;
          code_d   = mask;
          lights_d = ALL_RED;
`ifdef FAULT_FLASH_EN
          flash_d  = '0;
`endif
        end else begin
          lights_d = mon.lights_i;
        end
      end
      FAULT: begin
        if (clr_ok) begin
          state_d  = MONITOR;
          fault_d  = 1'b0;
          code_d   = '0;
          lights_d = mon.lights_i;
          stuck_d  = '0;
          for (int i = 0; i < 4; i++) ycnt_d[i] = YMIN;
        end else begin
`ifdef FAULT_FLASH_EN
          // Fault lamps are only ever all-red or all-dark, so inverting toggles between them.
          if (flash_q == FLAST) begin
            flash_d  = '0;
            lights_d = ~lights_q;
          end else begin
            flash_d  = flash_q + FW'(1);
          end
`else
          lights_d = ALL_RED;
`endif
        end
      end
      default: state_d = MONITOR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= MONITOR;
      prev_q   <= ALL_YEL;
      lights_q <= ALL_YEL;
      fault_q  <= 1'b0;
      code_q   <= '0;
      stuck_q  <= '0;
      for (int i = 0; i < 4; i++) ycnt_q[i] <= YMIN;
    end else begin
      state_q  <= state_d;
      prev_q   <= mon.lights_i;
      lights_q <= lights_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      stuck_q  <= stuck_d;
      for (int i = 0; i < 4; i++) ycnt_q[i] <= ycnt_d[i];
    end
  end

`ifdef FAULT_FLASH_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flash_q <= '0;
    else        flash_q <= flash_d;
  end
`endif

  assign mon.lights_o     = lights_q;
  assign mon.fault_o      = fault_q;
  assign mon.fault_code_o = code_q;
endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Self-checking bench for signal_conflict_monitor: directed table, multi-cycle sequences
// and random stimulus against a rule-level reference model.
module tb_signal_conflict_monitor;
  localparam int MIN_Y = 4;
  localparam int MAX_S = 64;
  localparam int FLASH = 8;

  logic clk;
  logic reset;
  signal_conflict_monitor_if bus();

  signal_conflict_monitor #(.MIN_YELLOW_CYC(MIN_Y), .MAX_STUCK_CYC(MAX_S), .FLASH_CYC(FLASH)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got lights=%02h fault=%0b code=%05b, want lights=%02h fault=%0b code=%05b",
               name, act[13:6], act[5], act[4:0], exp[13:6], exp[5], exp[4:0]);
    end
  endtask

  // Reference model: tracks run lengths in plain integers and applies the rules directly.
  logic [7:0] m_prev, m_out;
  logic       m_fault;
  logic [4:0] m_code;
  int         m_yrun [4];
  int         m_hold, m_age;

  function automatic void model_reset();
    m_prev = 8'h55; m_out = 8'h55; m_fault = 1'b0; m_code = '0;
    for (int a = 0; a < 4; a++) m_yrun[a] = MIN_Y;
    m_hold = 1; m_age = 0;
  endfunction

  function automatic void model_step(input logic [7:0] li, input logic clr);
    int greens, hold_new;
    logic ill, skp, shrt, conf, stk;
    logic [1:0] c, p;
    greens = 0; ill = 0; skp = 0; shrt = 0;
    for (int a = 0; a < 4; a++) begin
      c = li[2*a +: 2]; p = m_prev[2*a +: 2];
      if (c == 2'd3) ill = 1;
      if (c == 2'd2) greens++;
      if (p == 2'd2 && c == 2'd0) skp = 1;
      if (p == 2'd1 && c != 2'd1 && m_yrun[a] < MIN_Y) shrt = 1;
    end
    conf = (greens >= 2);
    hold_new = (li == m_prev) ? m_hold + 1 : 1;
    stk = (hold_new >= MAX_S);
    for (int a = 0; a < 4; a++)
      if (li[2*a +: 2] == 2'd1) m_yrun[a] = (m_prev[2*a +: 2] == 2'd1) ? m_yrun[a] + 1 : 1;
    if (!m_fault) begin
      if (ill || conf || skp || shrt || stk) begin
        m_fault = 1; m_code = {stk, shrt, skp, conf, ill}; m_out = 8'h00; m_age = 0;
      end else begin
        m_out = li;
      end
    end else if (clr && !ill && !conf) begin
      m_fault = 0; m_code = '0; m_out = li; hold_new = 1;
      for (int a = 0; a < 4; a++) m_yrun[a] = MIN_Y;
    end else begin
      m_age++;
`ifdef FAULT_FLASH_EN
      m_out = ((m_age / FLASH) % 2 == 1) ? 8'hFF : 8'h00;
`else
      m_out = 8'h00;
`endif
    end
    m_prev = li;
    m_hold = hold_new;
  endfunction

  task automatic cycle(input logic [7:0] li, input logic c);
    bus.lights_i = li; bus.clr_i = c;
    @(posedge clk); #1;
    model_step(li, c);
    chk("model", {bus.lights_o, bus.fault_o, bus.fault_code_o}, {m_out, m_fault, m_code});
  endtask

  typedef struct {
    logic [7:0] li;
    logic       clr;
    logic [7:0] eo;
    logic       ef;
    logic [4:0] ec;
  } vec_t;

  vec_t tbl [13];

  typedef struct { logic [7:0] v; int len; } phase_t;
  phase_t legal [10];

  initial begin
    logic [7:0] cur;
    logic [13:0] flash_exp;
    tbl[0]  = '{8'h55, 1'b0, 8'h55, 1'b0, 5'b00000};
    tbl[1]  = '{8'h88, 1'b0, 8'h00, 1'b1, 5'b00010};
    tbl[2]  = '{8'hA0, 1'b1, 8'h00, 1'b1, 5'b00010};
    tbl[3]  = '{8'h00, 1'b1, 8'h00, 1'b0, 5'b00000};
    tbl[4]  = '{8'h40, 1'b0, 8'h40, 1'b0, 5'b00000};
    tbl[5]  = '{8'h40, 1'b0, 8'h40, 1'b0, 5'b00000};
    tbl[6]  = '{8'h00, 1'b0, 8'h00, 1'b1, 5'b01000};
    tbl[7]  = '{8'h00, 1'b1, 8'h00, 1'b0, 5'b00000};
    tbl[8]  = '{8'h80, 1'b0, 8'h80, 1'b0, 5'b00000};
    tbl[9]  = '{8'h03, 1'b0, 8'h00, 1'b1, 5'b00101};
    tbl[10] = '{8'h03, 1'b1, 8'h00, 1'b1, 5'b00101};
    tbl[11] = '{8'h00, 1'b1, 8'h00, 1'b0, 5'b00000};
    tbl[12] = '{8'h80, 1'b1, 8'h80, 1'b0, 5'b00000};

    legal[0] = '{8'h55, 10}; legal[1] = '{8'h80, 10}; legal[2] = '{8'h50, 4};
    legal[3] = '{8'h20, 10}; legal[4] = '{8'h10, 4};  legal[5] = '{8'h08, 10};
    legal[6] = '{8'h04, 4};  legal[7] = '{8'h02, 10}; legal[8] = '{8'h01, 4};
    legal[9] = '{8'h80, 10};

    bus.lights_i = 8'h55; bus.clr_i = 1'b0; reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_values", {bus.lights_o, bus.fault_o, bus.fault_code_o}, {8'h55, 1'b0, 5'b0});
    reset = 1'b1;

    // Directed table: conflict, clear reject/accept, short yellow, skip+illegal, ignored clear.
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].li, tbl[i].clr);
      chk($sformatf("table_row%0d", i), {bus.lights_o, bus.fault_o, bus.fault_code_o},
          {tbl[i].eo, tbl[i].ef, tbl[i].ec});
      $display("row %0d: in=%02h clr=%0b -> lights=%02h fault=%0b code=%05b",
               i, tbl[i].li, tbl[i].clr, bus.lights_o, bus.fault_o, bus.fault_code_o);
    end

    // Stuck: 8'h80 was applied once by the last row; fault must appear on hold cycle 64.
    for (int k = 2; k <= 90; k++) begin
      cycle(8'h80, 1'b0);
      if (k == 63) chk("stuck_before", {bus.lights_o, bus.fault_o, bus.fault_code_o}, {8'h80, 1'b0, 5'b0});
      if (k == 64) begin
        chk("stuck_entry", {bus.lights_o, bus.fault_o, bus.fault_code_o}, {8'h00, 1'b1, 5'b10000});
        $display("stuck fault raised on hold cycle %0d", k);
      end
      if (k == 72) begin
`ifdef FAULT_FLASH_EN
        flash_exp = {8'hFF, 1'b1, 5'b10000};
`else
        flash_exp = {8'h00, 1'b1, 5'b10000};
`endif
        chk("fault_pattern_age8", {bus.lights_o, bus.fault_o, bus.fault_code_o}, flash_exp);
      end
    end

    // Asynchronous reset in the middle of a fault.
    #2 reset = 1'b0;
    #1 chk("async_reset", {bus.lights_o, bus.fault_o, bus.fault_code_o}, {8'h55, 1'b0, 5'b0});
    $display("async reset mid-fault: lights=%02h fault=%0b", bus.lights_o, bus.fault_o);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();

    // Legal FSM cycle: pure one-cycle pass-through, never a fault.
    for (int p = 0; p < 10; p++) begin
      for (int k = 0; k < legal[p].len; k++) begin
        cycle(legal[p].v, 1'b0);
        chk("legal_passthru", {bus.lights_o, bus.fault_o, bus.fault_code_o}, {legal[p].v, 1'b0, 5'b0});
      end
      $display("legal phase %02h x%0d: lights=%02h fault=%0b", legal[p].v, legal[p].len,
               bus.lights_o, bus.fault_o);
    end

    // Random walk: mostly hold, sometimes change one approach or the whole vector.
    cur = 8'h80;
    for (int k = 0; k < 3000; k++) begin
      int r;
      int a;
      r = $urandom_range(0, 99);
      if (r < 15) begin
        a = $urandom_range(0, 3);
        cur[2*a +: 2] = 2'($urandom_range(0, 3));
      end else if (r < 20) begin
        cur = 8'($urandom);
      end else if (r < 24) begin
        cur = 8'h00;
      end
      cycle(cur, ($urandom_range(0, 9) < 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/signal_conflict_monitor.md
Name: signal_conflict_monitor

Overview:
- Safety stage directly downstream of the four-approach traffic-light FSM.
- Consumes the FSM's packed lamp codes and passes them to the lamp drivers with one cycle of latency.
- Checks every cycle for unsafe light patterns. On any violation it latches a fault, overrides the lamps with a fail-safe pattern, and holds that state until an explicit clear.

Parameters:
- MIN_YELLOW_CYC, 4, minimum number of consecutive cycles an approach must show yellow before it leaves yellow.
- MAX_STUCK_CYC, 64, number of consecutive cycles with an unchanged input vector that counts as a stuck controller.
- FLASH_CYC, 8, half-period in cycles of the fail-safe flash; used only with FAULT_FLASH_EN.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- lights_i  input  8  lamp codes {north,east,south,west}, 2 bits each: 00 red, 01 yellow, 10 green, 11 illegal
- clr_i  input  1  fault clear request, level-sampled
- lights_o  output  8  lamp drive in the same encoding; 11 means dark, and is used only by the flash option
- fault_o  output  1  fault latched
- fault_code_o  output  5  violation mask captured at fault entry: bit0 ILLEGAL, bit1 CONFLICT, bit2 SKIP_YELLOW, bit3 SHORT_YELLOW, bit4 STUCK

Behaviour:
- Reset values:
  - Registered outputs: lights_o = 8'h55 (all yellow), fault_o = 0, fault_code_o = 0.
  - Internal state: FSM = MONITOR, prev = 8'h55, every per-approach yellow counter = MIN_YELLOW_CYC (counts as already satisfied), stuck counter = 0.
- Violation conditions, evaluated each cycle against prev (the vector registered on the previous cycle):
  - ILLEGAL: any approach code = 11.
  - CONFLICT: two or more approaches green.
  - SKIP_YELLOW: any approach with prev = green and current = red.
  - SHORT_YELLOW: any approach with prev = yellow, current not yellow, and yellow counter < MIN_YELLOW_CYC.
  - STUCK: stuck counter reaches MAX_STUCK_CYC - 1 while lights_i == prev.
- Counters:
  - Yellow counter (one per approach): loads 1 when the approach enters yellow, increments while it stays yellow, saturates at MIN_YELLOW_CYC.
  - Stuck counter: clears on any change of lights_i; otherwise increments, saturating.
  - Counter widths are $clog2(param+1).
- prev loads lights_i every cycle, in both states.
- MONITOR state:
  - No violation: lights_o <= lights_i, giving one-cycle latency.
  - Any violation: at the same edge, state <= FAULT, fault_o <= 1, fault_code_o <= the full mask of all conditions true that cycle, and lights_o <= the fail-safe pattern.
  - The offending vector never appears on lights_o.
- FAULT state:
  - lights_o shows the fail-safe pattern; fault_code_o holds its value.
  - No further violations are recorded.
- Clear:
  - clr_i = 1 in FAULT is accepted only if the current lights_i has no ILLEGAL and no CONFLICT.
  - On acceptance: state <= MONITOR, fault_o <= 0, fault_code_o <= 0, lights_o <= lights_i, yellow counters set to MIN_YELLOW_CYC, stuck counter <= 0.
  - A rejected clear has no effect.
  - clr_i in MONITOR is ignored.
- Simultaneous events:
  - Multiple violations in one cycle all set their mask bits.
  - If a clear is accepted in the same cycle as a SKIP_YELLOW or SHORT_YELLOW, the clear wins; those checks are suppressed in the clear cycle.
- Reset asserted mid-fault returns all outputs to their reset values asynchronously.
- Fail-safe pattern without the option: steady 8'h00 (all red).

Optional Feature:
- Macro: FAULT_FLASH_EN.
- When defined:
  - In FAULT, lights_o alternates between 8'h00 (all red) and 8'hFF (all dark) every FLASH_CYC cycles.
  - The pattern starts with all red on the fault-entry edge.
  - The flash counter is reset at fault entry.
- When undefined: steady all red, and no flash counter is present in the design.

Test Plan:
- Legal sequence. Stimulus: 55 → 80 → 50 (held 4 cycles) → 20, each phase held 10 cycles, then the full FSM cycle.
  - lights_o equals lights_i delayed by 1 cycle.
  - fault_o stays 0.
- Conflict. Stimulus: 8'h88 (north and south green).
  - Next edge: fault_o = 1, fault_code_o = 5'b00010, lights_o = 00.
  - 8'h88 never appears on lights_o.
- Short yellow. Stimulus: north yellow for 2 cycles, then red (MIN_YELLOW_CYC = 4).
  - fault_code_o = 5'b01000.
- Skip yellow plus illegal code. Stimulus: 8'h80 → 8'h03 in one step.
  - fault_code_o = 5'b00101.
- Stuck. Stimulus: 8'h80 held 70 cycles.
  - Fault raised on the 64th cycle of the hold, with code 5'b10000.
- Clear. In FAULT:
  - clr_i with lights_i = 8'hA0 is rejected; fault stays set.
  - clr_i with lights_i = 8'h00 is accepted; next edge fault_o = 0, lights_o = 00.
  - With FAULT_FLASH_EN, before the clear lights_o toggles 00/FF every 8 cycles.
  - Reset asserted mid-FAULT gives lights_o = 55 immediately.
